// File: rtl/switch_input_port_pkg.sv
// Shared definitions for the switch input port: bus width, register select codes, status bits.
package switch_input_port_pkg;

  localparam int IO_WIDTH = 16;

  typedef logic [IO_WIDTH-1:0] io_word_t;

  localparam logic [1:0] SWP_DATA = 2'b00;
  localparam logic [1:0] SWP_STAT = 2'b01;
  localparam logic [1:0] SWP_LIVE = 2'b10;

  localparam int VALID   = 0;
  localparam int OVERRUN = 1;

endpackage

// File: rtl/switch_input_port_if.sv
// Board + CPU read bus of the switch input port; master drives board pins and strobes, slave answers.
interface switch_input_port_if;
  import switch_input_port_pkg::*;

  io_word_t   switches;
  logic       confirm_button;
  logic       ior;
  logic       switchctrl;
  logic [1:0] ioaddr;
  io_word_t   ioread_data;
  logic       data_valid;

  modport master (
    output switches, confirm_button, ior, switchctrl, ioaddr,
    input  ioread_data, data_valid
  );

  modport slave (
    input  switches, confirm_button, ior, switchctrl, ioaddr,
    output ioread_data, data_valid
  );

endinterface

// File: rtl/switch_input_port_debounce.sv
// Counter debouncer: dout follows din after DEBOUNCE_CYCLES consecutive differing samples.
// Latency DEBOUNCE_CYCLES cycles; no backpressure, a bounce restarts the count.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      dout <= ~dout;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/switch_input_port.sv
// Debounced-press capture of board switches with a read/consume register window; press latency 2+DEBOUNCE_CYCLES+1.
// No backpressure: a press while valid is pending overwrites the data and flags overrun.
module switch_input_port
  import switch_input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic                clock,
  input  logic                reset,
  switch_input_port_if.slave  bus
);

  logic     btn_meta, btn_sync;
  io_word_t sw_meta, switches_s;
  logic     btn_db, btn_db_d;
  logic     press;
  io_word_t data_reg;
  logic     valid, overrun;
  logic     rd, rd_d, rd_edge;
  logic     data_rd, stat_rd;
  io_word_t stat_word;
  io_word_t rd_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta   <= 1'b0;
      btn_sync   <= 1'b0;
      sw_meta    <= '0;
      switches_s <= '0;
    end else begin
      btn_meta   <= bus.confirm_button;
      btn_sync   <= btn_meta;
      sw_meta    <= bus.switches;
      switches_s <= sw_meta;
    end
  end

  debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .din   (btn_sync),
    .dout  (btn_db)
  );

  assign press   = btn_db & ~btn_db_d;
  assign rd      = bus.ior & bus.switchctrl;
  assign rd_edge = rd & ~rd_d;
  assign data_rd = rd_edge && (bus.ioaddr == SWP_DATA);
  assign stat_rd = rd_edge && (bus.ioaddr == SWP_STAT);

  // A press coinciding with a data read counts as consumed-then-refilled, so no overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_db_d <= 1'b0;
      rd_d     <= 1'b0;
      data_reg <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      rd_d     <= rd;
      if (press) begin
        data_reg <= switches_s;
        valid    <= 1'b1;
      end else if (data_rd) begin
        valid <= 1'b0;
      end
      if (press && valid && !data_rd) begin
        overrun <= 1'b1;
      end else if (stat_rd) begin
        overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    stat_word          = '0;
    stat_word[VALID]   = valid;
    stat_word[OVERRUN] = overrun;
  end

  always_comb begin
    rd_data = '0;
    if (rd) begin
      case (bus.ioaddr)
        SWP_DATA: rd_data = data_reg;
        SWP_STAT: rd_data = stat_word;
        SWP_LIVE: rd_data = switches_s;
        default:  rd_data = '0;
      endcase
    end
  end

  assign bus.ioread_data = rd_data;
  assign bus.data_valid  = valid;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with a short debounce window.
module tb_switch_input_port;
  import switch_input_port_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] rv;

  switch_input_port_if bus ();

  switch_input_port #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One strobe cycle with its edge, then one idle cycle so the next read sees a fresh edge.
  task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
    bus.ioaddr     = a;
    bus.ior        = 1'b1;
    bus.switchctrl = 1'b1;
    #1;
    d = bus.ioread_data;
    tick(1);
    bus.ior        = 1'b0;
    bus.switchctrl = 1'b0;
    tick(1);
  endtask

  task automatic press_release(input logic [15:0] v);
    bus.switches       = v;
    bus.confirm_button = 1'b1;
    tick(7);
    bus.confirm_button = 1'b0;
    tick(7);
  endtask

  initial begin
    reset              = 1'b1;
    bus.switches       = '0;
    bus.confirm_button = 1'b0;
    bus.ior            = 1'b0;
    bus.switchctrl     = 1'b0;
    bus.ioaddr         = SWP_DATA;
    tick(2);
    bus.ior        = 1'b1;
    bus.switchctrl = 1'b1;
    #1;
    chk("rst_rdata", bus.ioread_data, 16'h0000);
    chk("rst_valid", {15'b0, bus.data_valid}, 16'h0000);
    bus.ior        = 1'b0;
    bus.switchctrl = 1'b0;
    tick(1);
    reset = 1'b0;

    // clean press
    bus.switches       = 16'hA5C3;
    bus.confirm_button = 1'b1;
    tick(6);
    chk("clean_c6", {15'b0, bus.data_valid}, 16'h0000);
    tick(1);
    chk("clean_c7", {15'b0, bus.data_valid}, 16'h0001);
    rd_reg(SWP_DATA, rv);
    chk("clean_data", rv, 16'hA5C3);
    chk("clean_consumed", {15'b0, bus.data_valid}, 16'h0000);
    rd_reg(SWP_STAT, rv);
    chk("clean_stat", rv, 16'h0000);
    bus.confirm_button = 1'b0;
    tick(7);
    chk("release_no_evt", {15'b0, bus.data_valid}, 16'h0000);

    // reset mid-read with a pending value and the button held high
    bus.switches       = 16'h1234;
    bus.confirm_button = 1'b1;
    tick(7);
    bus.ioaddr     = SWP_DATA;
    bus.ior        = 1'b1;
    bus.switchctrl = 1'b1;
    #1;
    chk("prerst_data", bus.ioread_data, 16'h1234);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_rdata", bus.ioread_data, 16'h0000);
    chk("midrst_valid", {15'b0, bus.data_valid}, 16'h0000);
    bus.ior        = 1'b0;
    bus.switchctrl = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("postrst_c6", {15'b0, bus.data_valid}, 16'h0000);
    tick(1);
    chk("postrst_c7", {15'b0, bus.data_valid}, 16'h0001);
    rd_reg(SWP_DATA, rv);
    chk("postrst_data", rv, 16'h1234);
    bus.confirm_button = 1'b0;
    tick(7);

    // bounce: 2-cycle pulses never reach the debounce window
    bus.switches = 16'hBEEF;
    for (int i = 0; i < 20; i++) begin
      bus.confirm_button = ((i / 2) % 2) == 0;
      tick(1);
    end
    chk("bounce_none", {15'b0, bus.data_valid}, 16'h0000);
    bus.confirm_button = 1'b1;
    tick(6);
    chk("bounce_c6", {15'b0, bus.data_valid}, 16'h0000);
    tick(1);
    chk("bounce_c7", {15'b0, bus.data_valid}, 16'h0001);
    rd_reg(SWP_STAT, rv);
    chk("bounce_stat", rv, 16'h0001);
    rd_reg(SWP_DATA, rv);
    chk("bounce_data", rv, 16'hBEEF);
    bus.confirm_button = 1'b0;
    tick(7);

    // overrun
    press_release(16'h0001);
    press_release(16'h0002);
    rd_reg(SWP_STAT, rv);
    chk("ovr_stat1", rv, 16'h0003);
    rd_reg(SWP_DATA, rv);
    chk("ovr_data", rv, 16'h0002);
    rd_reg(SWP_STAT, rv);
    chk("ovr_stat2", rv, 16'h0000);

    // press on the same edge as a data read
    press_release(16'h0055);
    bus.switches       = 16'h00FF;
    bus.confirm_button = 1'b1;
    tick(6);
    bus.ioaddr     = SWP_DATA;
    bus.ior        = 1'b1;
    bus.switchctrl = 1'b1;
    #1;
    chk("coll_old", bus.ioread_data, 16'h0055);
    tick(1);
    chk("coll_valid", {15'b0, bus.data_valid}, 16'h0001);
    bus.ior        = 1'b0;
    bus.switchctrl = 1'b0;
    tick(1);
    rd_reg(SWP_STAT, rv);
    chk("coll_stat", rv, 16'h0001);
    rd_reg(SWP_DATA, rv);
    chk("coll_data", rv, 16'h00FF);
    bus.confirm_button = 1'b0;
    tick(7);

    // 3-cycle data strobe with the press landing in its 2nd cycle
    bus.switches       = 16'h1357;
    bus.confirm_button = 1'b1;
    tick(5);
    bus.ioaddr     = SWP_DATA;
    bus.ior        = 1'b1;
    bus.switchctrl = 1'b1;
    tick(2);
    chk("held_c2", {15'b0, bus.data_valid}, 16'h0001);
    tick(1);
    chk("held_c3", {15'b0, bus.data_valid}, 16'h0001);
    bus.ior        = 1'b0;
    bus.switchctrl = 1'b0;
    tick(1);
    chk("held_after", {15'b0, bus.data_valid}, 16'h0001);
    rd_reg(SWP_DATA, rv);
    chk("held_data", rv, 16'h1357);
    chk("held_consumed", {15'b0, bus.data_valid}, 16'h0000);
    bus.confirm_button = 1'b0;
    tick(7);

    // live switches, reserved address, idle strobe
    bus.switches = 16'hC0DE;
    tick(2);
    bus.ioaddr     = SWP_LIVE;
    bus.ior        = 1'b1;
    bus.switchctrl = 1'b1;
    #1;
    chk("live", bus.ioread_data, 16'hC0DE);
    bus.switches = 16'h1111;
    #1;
    chk("live_sync0", bus.ioread_data, 16'hC0DE);
    tick(1);
    chk("live_sync1", bus.ioread_data, 16'hC0DE);
    tick(1);
    chk("live_sync2", bus.ioread_data, 16'h1111);
    bus.ioaddr = 2'b11;
    #1;
    chk("reserved", bus.ioread_data, 16'h0000);
    bus.ioaddr     = SWP_LIVE;
    bus.switchctrl = 1'b0;
    #1;
    chk("no_sel", bus.ioread_data, 16'h0000);
    bus.ior        = 1'b0;
    bus.switchctrl = 1'b1;
    #1;
    chk("no_ior", bus.ioread_data, 16'h0000);
    bus.switchctrl = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
